// File: rtl/isp_crop_cfg_ctrl.sv
// isp_crop_cfg_ctrl: frame-synchronous crop margin controller.
// Software stages margins, commits them. Validated margins wait as pending
// and move to the active set only at a frame start (vsync falling edge).
// The block also measures the incoming frame size from href/vsync.
module isp_crop_cfg_ctrl #(
   parameter int WIDTH      = 4096,
   parameter int HEIGHT     = 4096,
   parameter int BAYER_EVEN = 1
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        cfg_wr,
   input  logic [1:0]  cfg_addr,
   input  logic [11:0] cfg_wdata,
   input  logic        cfg_commit,
   input  logic        in_href,
   input  logic        in_vsync,
   output logic [11:0] crop_left,
   output logic [11:0] crop_right,
   output logic [11:0] crop_top,
   output logic [11:0] crop_bottom,
   output logic        cfg_pending,
   output logic        cfg_applied,
   output logic        cfg_err,
   output logic        size_err,
   output logic [15:0] meas_width,
   output logic [15:0] meas_height,
   output logic [15:0] frame_cnt
);

   localparam logic [12:0] WIDTH_C   = 13'(WIDTH);
   localparam logic [12:0] HEIGHT_C  = 13'(HEIGHT);
   localparam logic [15:0] WIDTH_W   = 16'(WIDTH);
   localparam logic [15:0] HEIGHT_W  = 16'(HEIGHT);
   localparam logic [15:0] CNT_MAX   = 16'hFFFF;

   typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

   // Margin set validity: both axis sums fit the frame, and Bayer phase kept.
   function automatic logic cfg_valid(input logic [11:0] l, input logic [11:0] r,
                                      input logic [11:0] t, input logic [11:0] b);
      logic [12:0] sum_lr;
      logic [12:0] sum_tb;
      logic        even_ok;
      sum_lr = {1'b0, l} + {1'b0, r};
      sum_tb = {1'b0, t} + {1'b0, b};
      if (BAYER_EVEN != 0) begin
         even_ok = ~(l[0] | r[0] | t[0] | b[0]);
      end else begin
         even_ok = 1'b1;
      end
      return (sum_lr < WIDTH_C) && (sum_tb < HEIGHT_C) && even_ok;
   endfunction

   logic [11:0] stg_r [4];
   logic [11:0] pnd_r [4];
   state_t      state_r;
   logic        prev_vsync_r;
   logic        prev_href_r;
   logic [15:0] hcnt_r;
   logic [15:0] last_w_r;
   logic [15:0] vcnt_r;

   logic        frame_start_s;
   logic        line_start_s;
   logic        line_end_s;
   logic        stg_ok_s;
   logic        commit_ok_s;
   logic        commit_bad_s;

   assign frame_start_s = prev_vsync_r & ~in_vsync;
   assign line_start_s  = ~prev_href_r & in_href;
   assign line_end_s    = prev_href_r & ~in_href;
   // Commit sees staging as registered before this cycle, so a same-cycle write is excluded.
   assign stg_ok_s      = cfg_valid(stg_r[0], stg_r[1], stg_r[2], stg_r[3]);
   assign commit_ok_s   = cfg_commit & stg_ok_s;
   assign commit_bad_s  = cfg_commit & ~stg_ok_s;
   assign cfg_pending   = (state_r == ARMED);

   // Staging register file written by software.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) stg_r[i] <= 12'd0;
      end else if (cfg_wr) begin
         stg_r[cfg_addr] <= cfg_wdata;
      end
   end

   // Commit/apply FSM: pending set, active margins, applied pulse, sticky error.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         for (int i = 0; i < 4; i++) pnd_r[i] <= 12'd0;
         crop_left   <= 12'd0;
         crop_right  <= 12'd0;
         crop_top    <= 12'd0;
         crop_bottom <= 12'd0;
         cfg_applied <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         cfg_applied <= 1'b0;
         if (commit_ok_s) begin
            for (int i = 0; i < 4; i++) pnd_r[i] <= stg_r[i];
            cfg_err <= 1'b0;
         end else if (commit_bad_s) begin
            cfg_err <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               if (commit_ok_s) state_r <= ARMED;
            end
            ARMED: begin
               if (frame_start_s) begin
                  // Active takes the old pending value; a same-cycle valid commit re-arms.
                  crop_left   <= pnd_r[0];
                  crop_right  <= pnd_r[1];
                  crop_top    <= pnd_r[2];
                  crop_bottom <= pnd_r[3];
                  cfg_applied <= 1'b1;
                  state_r     <= commit_ok_s ? ARMED : IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Previous-cycle copies of href/vsync for edge detection.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         prev_vsync_r <= 1'b0;
         prev_href_r  <= 1'b0;
      end else begin
         prev_vsync_r <= in_vsync;
         prev_href_r  <= in_href;
      end
   end

   // Frame geometry measurement, latched into outputs at each frame start.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_r      <= 16'd0;
         last_w_r    <= 16'd0;
         vcnt_r      <= 16'd0;
         meas_width  <= 16'd0;
         meas_height <= 16'd0;
         size_err    <= 1'b0;
         frame_cnt   <= 16'd0;
      end else begin
         if (line_start_s) begin
            hcnt_r <= 16'd1;
         end else if (in_href && hcnt_r != CNT_MAX) begin
            hcnt_r <= hcnt_r + 16'd1;
         end
         if (line_end_s) last_w_r <= hcnt_r;
         if (frame_start_s) begin
            // A line starting in the frame-start cycle is the new frame's first line.
            vcnt_r      <= line_start_s ? 16'd1 : 16'd0;
            meas_width  <= last_w_r;
            meas_height <= vcnt_r;
            size_err    <= (last_w_r != WIDTH_W) | (vcnt_r != HEIGHT_W);
            frame_cnt   <= frame_cnt + 16'd1;
         end else if (line_start_s && vcnt_r != CNT_MAX) begin
            vcnt_r <= vcnt_r + 16'd1;
         end
      end
   end

endmodule
